// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: register address width,
// the per-stage producer tag layout, the empty (bubble) tag and the operand match helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;

    // One in-flight producer: {valid, wen, waddr, is_load, is_mfc0}, MSB first.
    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [REG_ADDR_W-1:0] waddr;
        logic                  is_load;
        logic                  is_mfc0;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // A stage forwards to an operand only if it really writes a GPR other than r0.
    function automatic logic tag_match(input tag_t t, input logic [REG_ADDR_W-1:0] op);
        return t.valid && t.wen && (t.waddr != '0) && (t.waddr == op);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_stage_tag.sv
// One pipeline-stage tag register with clear, hold and load controls.
// Latency: 1 cycle from d to q. Backpressure: hold keeps q; clr (and reset) beat hold.
// Ports: clk, resetn (sync, active low), clr, hold, d (next tag), q (current tag).
module stage_tag_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic hold,
    input  tag_t d,
    output tag_t q
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= TAG_BUBBLE;
        end else if (clr) begin
            q <= TAG_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM/WB destination tags and produces per-operand nearest-producer and producer-type flags.
// Latency: flags are combinational (zero cycles) from registered tags and the ID inputs.
// Backpressure: id_stall inserts a bubble into EX; pipe_freeze holds all tags; flush kills EX/MEM.
//
// Ports: clk, resetn (sync, active low), flush, pipe_freeze, id_stall, the ID instruction
// (id_valid, id_rs, id_rt, id_wen, id_waddr, id_is_load, id_is_mfc0), producer-type outputs
// (reg_write_is_mem_EX, mfc0_EX, mfc0_MEM) and rs_/rt_data_ID_is_from_{ex,mem,wb}.
// Optional macro HAZARD_SCOREBOARD_STATS_EN adds stat_bubbles, a count of id_stall bubbles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  pipe_freeze,
    input  logic                  id_stall,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_wen,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_is_load,
    input  logic                  id_is_mfc0,
    output logic                  reg_write_is_mem_EX,
    output logic                  mfc0_EX,
    output logic                  mfc0_MEM,
    output logic                  rs_data_ID_is_from_ex,
    output logic                  rs_data_ID_is_from_mem,
    output logic                  rs_data_ID_is_from_wb,
    output logic                  rt_data_ID_is_from_ex,
    output logic                  rt_data_ID_is_from_mem,
`ifdef HAZARD_SCOREBOARD_STATS_EN
    output logic                  rt_data_ID_is_from_wb,
    output logic [31:0]           stat_bubbles
`else
    output logic                  rt_data_ID_is_from_wb
`endif
);

    tag_t id_tag;
    tag_t ex_d;
    tag_t ex_q;
    tag_t mem_q;
    tag_t wb_q;

    always_comb begin
        id_tag.valid   = id_valid;
        id_tag.wen     = id_wen;
        id_tag.waddr   = id_waddr;
        id_tag.is_load = id_is_load;
        id_tag.is_mfc0 = id_is_mfc0;
    end

    // A stalled ID instruction stays in ID and is re-presented; EX sees a bubble meanwhile.
    assign ex_d = (id_valid && !id_stall) ? id_tag : TAG_BUBBLE;

    stage_tag_reg u_ex (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .hold   (pipe_freeze),
        .d      (ex_d),
        .q      (ex_q)
    );

    stage_tag_reg u_mem (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .hold   (pipe_freeze),
        .d      (ex_q),
        .q      (mem_q)
    );

    // WB keeps advancing on flush (flush overrides freeze); the dropped MEM instruction
    // moves into WB, matching the original pipeline's behaviour.
    stage_tag_reg u_wb (
        .clk    (clk),
        .resetn (resetn),
        .clr    (1'b0),
        .hold   (pipe_freeze && !flush),
        .d      (mem_q),
        .q      (wb_q)
    );

    logic rs_m_ex, rs_m_mem, rs_m_wb;
    logic rt_m_ex, rt_m_mem, rt_m_wb;

    assign rs_m_ex  = tag_match(ex_q,  id_rs);
    assign rs_m_mem = tag_match(mem_q, id_rs);
    assign rs_m_wb  = tag_match(wb_q,  id_rs);
    assign rt_m_ex  = tag_match(ex_q,  id_rt);
    assign rt_m_mem = tag_match(mem_q, id_rt);
    assign rt_m_wb  = tag_match(wb_q,  id_rt);

    // Nearest (youngest) producer wins.
    assign rs_data_ID_is_from_ex  = rs_m_ex;
    assign rs_data_ID_is_from_mem = rs_m_mem && !rs_m_ex;
    assign rs_data_ID_is_from_wb  = rs_m_wb && !rs_m_mem && !rs_m_ex;
    assign rt_data_ID_is_from_ex  = rt_m_ex;
    assign rt_data_ID_is_from_mem = rt_m_mem && !rt_m_ex;
    assign rt_data_ID_is_from_wb  = rt_m_wb && !rt_m_mem && !rt_m_ex;

    assign reg_write_is_mem_EX = ex_q.valid  && ex_q.wen  && ex_q.is_load;
    assign mfc0_EX             = ex_q.valid  && ex_q.wen  && ex_q.is_mfc0;
    assign mfc0_MEM            = mem_q.valid && mem_q.wen && mem_q.is_mfc0;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    // Counts only genuine advances (no flush, no freeze) that turn a valid ID op into a bubble.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_bubbles <= '0;
        end else if (!flush && !pipe_freeze && id_stall && id_valid) begin
            stat_bubbles <= stat_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       resetn, flush, pipe_freeze, id_stall, id_valid;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       id_wen, id_is_load, id_is_mfc0;
    logic       reg_write_is_mem_EX, mfc0_EX, mfc0_MEM;
    logic       rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stat_bubbles;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    logic       m_valid [3];
    logic       m_wen   [3];
    logic [4:0] m_waddr [3];
    logic       m_load  [3];
    logic       m_mfc0  [3];
    logic [31:0] m_stats;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .flush                  (flush),
        .pipe_freeze            (pipe_freeze),
        .id_stall               (id_stall),
        .id_valid               (id_valid),
        .id_rs                  (id_rs),
        .id_rt                  (id_rt),
        .id_wen                 (id_wen),
        .id_waddr               (id_waddr),
        .id_is_load             (id_is_load),
        .id_is_mfc0             (id_is_mfc0),
        .reg_write_is_mem_EX    (reg_write_is_mem_EX),
        .mfc0_EX                (mfc0_EX),
        .mfc0_MEM               (mfc0_MEM),
        .rs_data_ID_is_from_ex  (rs_ex),
        .rs_data_ID_is_from_mem (rs_mem),
        .rs_data_ID_is_from_wb  (rs_wb),
        .rt_data_ID_is_from_ex  (rt_ex),
        .rt_data_ID_is_from_mem (rt_mem),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .rt_data_ID_is_from_wb  (rt_wb),
        .stat_bubbles           (stat_bubbles)
`else
        .rt_data_ID_is_from_wb  (rt_wb)
`endif
    );

    function automatic logic live(input int s);
        return m_valid[s] && m_wen[s];
    endfunction

    // Stage index of the youngest producer of op, or 3 if none.
    function automatic int nearest(input logic [4:0] op);
        int src = 3;
        for (int s = 2; s >= 0; s--)
            if (live(s) && op != 5'd0 && m_waddr[s] == op) src = s;
        return src;
    endfunction

    function automatic logic [8:0] model_out();
        int rs_src = nearest(id_rs);
        int rt_src = nearest(id_rt);
        return {live(0) && m_load[0], live(0) && m_mfc0[0], live(1) && m_mfc0[1],
                rs_src == 0, rs_src == 1, rs_src == 2,
                rt_src == 0, rt_src == 1, rt_src == 2};
    endfunction

    function automatic logic [8:0] dut_out();
        return {reg_write_is_mem_EX, mfc0_EX, mfc0_MEM, rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb};
    endfunction

    task automatic check(input string tag);
        logic [8:0] exp_v = model_out();
        logic [8:0] got_v;
        #1;
        got_v = dut_out();
        n_checks++;
        assert (got_v === exp_v) else begin
            n_fails++;
            $error("FAIL %s: outputs observed %b expected %b", tag, got_v, exp_v);
        end
`ifdef HAZARD_SCOREBOARD_STATS_EN
        n_checks++;
        assert (stat_bubbles === m_stats) else begin
            n_fails++;
            $error("FAIL %s_stats: stat_bubbles observed %0d expected %0d", tag, stat_bubbles, m_stats);
        end
`endif
    endtask

    // Directed bit check against a constant drawn from the scenario itself.
    task automatic expect_bit(input string tag, input logic got, input logic exp_b);
        n_checks++;
        assert (got === exp_b) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp_b);
        end
    endtask

    task automatic set_id(input logic v, input logic wen, input logic [4:0] wa,
                          input logic ld, input logic mf, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = v; id_wen = wen; id_waddr = wa; id_is_load = ld; id_is_mfc0 = mf;
        id_rs = rs; id_rt = rt;
    endtask

    task automatic set_ctl(input logic rn, input logic fl, input logic fz, input logic st);
        resetn = rn; flush = fl; pipe_freeze = fz; id_stall = st;
    endtask

    // Clock edge, then update the reference pipeline with the inputs that were presented.
    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            for (int s = 0; s < 3; s++) m_valid[s] = 1'b0;
            m_stats = 32'd0;
        end else if (flush) begin
            m_valid[2] = m_valid[1]; m_wen[2] = m_wen[1]; m_waddr[2] = m_waddr[1];
            m_load[2] = m_load[1]; m_mfc0[2] = m_mfc0[1];
            m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        end else if (!pipe_freeze) begin
            for (int s = 2; s > 0; s--) begin
                m_valid[s] = m_valid[s-1]; m_wen[s] = m_wen[s-1]; m_waddr[s] = m_waddr[s-1];
                m_load[s] = m_load[s-1]; m_mfc0[s] = m_mfc0[s-1];
            end
            m_valid[0] = id_valid && !id_stall;
            m_wen[0] = id_wen; m_waddr[0] = id_waddr; m_load[0] = id_is_load; m_mfc0[0] = id_is_mfc0;
            if (id_stall && id_valid) m_stats = m_stats + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            m_valid[s] = 1'b0; m_wen[s] = 1'b0; m_waddr[s] = 5'd0; m_load[s] = 1'b0; m_mfc0[s] = 1'b0;
        end
        m_stats = 32'd0;
        @(negedge clk);

        // 1: reset with a load to r5 sitting in ID
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5);
        tick();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5);
        check("reset");
        expect_bit("reset_load_ex", reg_write_is_mem_EX, 1'b0);

        // 2: load r5, then a reader of r5 that gets stalled one cycle
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
        tick();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd6);
        check("load_ex");
        expect_bit("load_ex_flag", reg_write_is_mem_EX, 1'b1);
        expect_bit("load_rs_from_ex", rs_ex, 1'b1);
        id_stall = 1'b1;
        tick();
        id_stall = 1'b0;
        check("after_stall");
        expect_bit("stall_rs_from_ex", rs_ex, 1'b0);
        expect_bit("stall_rs_from_mem", rs_mem, 1'b1);
        expect_bit("stall_ex_empty", reg_write_is_mem_EX, 1'b0);
        tick();

        // 3: r3 written by both EX and MEM; EX must win
        set_id(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd3);
        check("r3_nearest");
        expect_bit("r3_from_ex", rs_ex, 1'b1);
        expect_bit("r3_from_mem", rs_mem, 1'b0);
        expect_bit("r3_rt_same", rt_ex, 1'b1);

        // 4: write to r0 never produces a hazard
        set_id(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check("r0_write");
            expect_bit("r0_any_flag", rs_ex | rs_mem | rs_wb, 1'b0);
            tick();
        end

        // 5: mfc0 r8 held in EX by a 3-cycle freeze
        set_id(1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd0);
        pipe_freeze = 1'b1;
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("freeze");
            expect_bit("freeze_mfc0_ex", mfc0_EX, 1'b1);
            tick();
        end
        pipe_freeze = 1'b0;
        id_stall = 1'b0;
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd0);
        tick();
        check("unfreeze");
        expect_bit("unfreeze_mfc0_mem", mfc0_MEM, 1'b1);
        expect_bit("unfreeze_rs_from_mem", rs_mem, 1'b1);

        // 6: flush with r9 in MEM and r10 in EX; WB must receive r9
        set_id(1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush");
        expect_bit("flush_rs_from_wb", rs_wb, 1'b1);
        expect_bit("flush_rt_any", rt_ex | rt_mem | rt_wb, 1'b0);

        // Randomised traffic against the reference pipeline
        for (int i = 0; i < 600; i++) begin
            set_ctl($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            set_id(1'(($urandom_range(0, 3)) != 0), 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) id_rt = id_rs;
            check("random");
            tick();
        end
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        check("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
